// File: rtl/lsu_bif_pkg.sv
// Shared types and constants for the load/store bus interface.
package lsu_bif_pkg;

    // Bus-interface FSM states, two-bit encoding
    typedef enum logic [1:0] {
        LSB_ST_IDLE = 2'd0,
        LSB_ST_CMD  = 2'd1,
        LSB_ST_RSP  = 2'd2,
        LSB_ST_DONE = 2'd3
    } lsb_state_e;

    // Default response-wait budget and counter width
    localparam int LSB_TMO_DEF   = 255;
    localparam int LSB_TMO_W_DEF = 8;

    // Byte-lane bits of the address are not carried onto the word bus
    localparam logic [31:0] LSB_ADR_MASK = 32'hFFFF_FFFC;

    // Word-align a byte address
    function automatic logic [31:0] lsb_word_adr(input logic [31:0] adr);
        return adr & LSB_ADR_MASK;
    endfunction

    // A request with neither read nor any write lane does not touch the bus
    function automatic logic lsb_is_noop(input logic ren, input logic [3:0] wen);
        return (~ren) & (~(|wen));
    endfunction

endpackage

// File: rtl/lsu_tmo.sv
// Response timeout counter: clearable, enabled, saturating at TMO_CYC-1.
// tc flags the last wait cycle that may still accept a response.
module lsu_tmo
    import lsu_bif_pkg::*;
#(
    parameter int TMO_W   = LSB_TMO_W_DEF,
    parameter int TMO_CYC = LSB_TMO_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] cnt_r;

    // Count enabled wait cycles; clear has priority, hold once terminal count is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {TMO_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {TMO_W{1'b0}};
        end else if (en && (cnt_r != TC_VAL)) begin
            cnt_r <= cnt_r + TMO_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/lsu_bif.sv
// Load/store bus interface: takes one execute-stage request at a time and
// runs it over a split command/response bus with a response timeout.
module lsu_bif
    import lsu_bif_pkg::*;
#(
    parameter int TMO_CYC = LSB_TMO_DEF,
    parameter int TMO_W   = LSB_TMO_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_ex4ls_val,
    output logic        hs_ls4ex_rdy,
    input  logic [31:0] i_ls_adr,
    input  logic [31:0] i_ls_wdat,
    input  logic [3:0]  i_ls_wen,
    input  logic        i_ls_ren,
    output logic [31:0] o_ls_rdat,
    output logic        o_ls_err,
    output logic        o_mem_cmd_val,
    input  logic        i_mem_cmd_rdy,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_wdat,
    output logic [3:0]  o_mem_wstrb,
    output logic        o_mem_wr,
    input  logic        i_mem_rsp_val,
    output logic        o_mem_rsp_rdy,
    input  logic [31:0] i_mem_rsp_dat,
    input  logic        i_mem_rsp_err
);

    lsb_state_e  state_r;
    lsb_state_e  state_s;
    logic        launch_s;
    logic        tmo_clr_s;
    logic        tmo_en_s;
    logic        tmo_tc_s;
    logic        rsp_fire_s;
    logic [31:0] rdat_s;
    logic        err_s;

    assign rsp_fire_s = i_mem_rsp_val & o_mem_rsp_rdy;

    lsu_tmo #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmo_clr_s),
        .en    (tmo_en_s),
        .tc    (tmo_tc_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LSB_ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, timeout control and completion data
    always_comb begin
        state_s   = state_r;
        launch_s  = 1'b0;
        tmo_clr_s = 1'b0;
        tmo_en_s  = 1'b0;
        rdat_s    = 32'h0000_0000;
        err_s     = 1'b0;
        case (state_r)
            LSB_ST_IDLE: begin
                // Responses arriving here are stale and simply dropped
                if (hs_ex4ls_val) begin
                    if (lsb_is_noop(i_ls_ren, i_ls_wen)) begin
                        state_s = LSB_ST_DONE;
                    end else begin
                        state_s  = LSB_ST_CMD;
                        launch_s = 1'b1;
                    end
                end else begin
                    state_s = LSB_ST_IDLE;
                end
            end
            LSB_ST_CMD: begin
                // No timeout while the slave holds off the command
                if (i_mem_cmd_rdy) begin
                    state_s   = LSB_ST_RSP;
                    tmo_clr_s = 1'b1;
                end else begin
                    state_s = LSB_ST_CMD;
                end
            end
            LSB_ST_RSP: begin
                // A response on the last allowed cycle wins over the timeout
                if (rsp_fire_s) begin
                    state_s = LSB_ST_DONE;
                    rdat_s  = o_mem_wr ? 32'h0000_0000 : i_mem_rsp_dat;
                    err_s   = i_mem_rsp_err;
                end else if (tmo_tc_s) begin
                    state_s = LSB_ST_DONE;
                    err_s   = 1'b1;
                end else begin
                    state_s  = LSB_ST_RSP;
                    tmo_en_s = 1'b1;
                end
            end
            LSB_ST_DONE: begin
                // Execute updates its request only after seeing rdy, so never relaunch here
                state_s = LSB_ST_IDLE;
            end
            default: begin
                state_s = LSB_ST_IDLE;
            end
        endcase
    end

    // Handshake and completion outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mem_cmd_val <= 1'b0;
            o_mem_rsp_rdy <= 1'b0;
            hs_ls4ex_rdy  <= 1'b0;
            o_ls_rdat     <= 32'h0000_0000;
            o_ls_err      <= 1'b0;
        end else begin
            o_mem_cmd_val <= (state_s == LSB_ST_CMD);
            o_mem_rsp_rdy <= (state_s == LSB_ST_IDLE) || (state_s == LSB_ST_RSP);
            hs_ls4ex_rdy  <= (state_s == LSB_ST_DONE);
            o_ls_rdat     <= rdat_s;
            o_ls_err      <= err_s;
        end
    end

    // Command fields captured at launch and held stable until the next launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mem_adr   <= 32'h0000_0000;
            o_mem_wdat  <= 32'h0000_0000;
            o_mem_wstrb <= 4'h0;
            o_mem_wr    <= 1'b0;
        end else if (launch_s) begin
            o_mem_adr   <= lsb_word_adr(i_ls_adr);
            o_mem_wdat  <= i_ls_wdat;
            o_mem_wstrb <= i_ls_wen;
            o_mem_wr    <= |i_ls_wen;
        end else begin
            o_mem_adr   <= o_mem_adr;
            o_mem_wdat  <= o_mem_wdat;
            o_mem_wstrb <= o_mem_wstrb;
            o_mem_wr    <= o_mem_wr;
        end
    end

endmodule

// File: tb/tb_lsu_bif.sv
// Self-checking bench for lsu_bif: directed table, corner sequences, random traffic.
module tb_lsu_bif;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        hs_ex4ls_val;
    logic        hs_ls4ex_rdy;
    logic [31:0] i_ls_adr;
    logic [31:0] i_ls_wdat;
    logic [3:0]  i_ls_wen;
    logic        i_ls_ren;
    logic [31:0] o_ls_rdat;
    logic        o_ls_err;
    logic        o_mem_cmd_val;
    logic        i_mem_cmd_rdy;
    logic [31:0] o_mem_adr;
    logic [31:0] o_mem_wdat;
    logic [3:0]  o_mem_wstrb;
    logic        o_mem_wr;
    logic        i_mem_rsp_val;
    logic        o_mem_rsp_rdy;
    logic [31:0] i_mem_rsp_dat;
    logic        i_mem_rsp_err;

    int errors = 0;
    int checks = 0;

    lsu_bif #(.TMO_CYC(TMO), .TMO_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hs_ex4ls_val  (hs_ex4ls_val),
        .hs_ls4ex_rdy  (hs_ls4ex_rdy),
        .i_ls_adr      (i_ls_adr),
        .i_ls_wdat     (i_ls_wdat),
        .i_ls_wen      (i_ls_wen),
        .i_ls_ren      (i_ls_ren),
        .o_ls_rdat     (o_ls_rdat),
        .o_ls_err      (o_ls_err),
        .o_mem_cmd_val (o_mem_cmd_val),
        .i_mem_cmd_rdy (i_mem_cmd_rdy),
        .o_mem_adr     (o_mem_adr),
        .o_mem_wdat    (o_mem_wdat),
        .o_mem_wstrb   (o_mem_wstrb),
        .o_mem_wr      (o_mem_wr),
        .i_mem_rsp_val (i_mem_rsp_val),
        .o_mem_rsp_rdy (o_mem_rsp_rdy),
        .i_mem_rsp_dat (i_mem_rsp_dat),
        .i_mem_rsp_err (i_mem_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic [3:0]  wen;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          cw;       // cycles the slave holds off the command
        int          rw;       // cycles in RSP before the slave answers
        logic [31:0] dat;
        logic        rerr;
        logic [31:0] exp_adr;
        logic        exp_wr;
        logic [31:0] exp_rdat;
        logic        exp_err;
        int          exp_lat;  // cycles from request to rdy
        int          exp_ncmd; // cycles cmd_val is seen high
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: outcome of a request from the bus rules, with TMO wait cycles allowed
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic noop;
        logic tmo;
        r          = v;
        noop       = (v.ren == 1'b0) && (v.wen == 4'h0);
        tmo        = !noop && (v.rw >= TMO);
        r.exp_adr  = {v.adr[31:2], 2'b00};
        r.exp_wr   = (v.wen != 4'h0);
        r.exp_ncmd = noop ? 0 : v.cw + 1;
        r.exp_lat  = noop ? 1 : (tmo ? 2 + v.cw + TMO : 3 + v.cw + v.rw);
        r.exp_rdat = (noop || tmo || r.exp_wr) ? 32'h0 : v.dat;
        r.exp_err  = noop ? 1'b0 : (tmo ? 1'b1 : v.rerr);
        return r;
    endfunction

    // Present one request and play the memory slave until completion
    task automatic run_txn(input vec_t v, input string name);
        int  n = 0;
        int  cmd_cyc = 0;
        int  first_cmd = -1;
        int  wait_c = 0;
        int  rsp_c = 0;
        bit  accepted = 1'b0;
        bit  rsp_sent = 1'b0;
        bit  done = 1'b0;
        hs_ex4ls_val  = 1'b1;
        i_ls_ren      = v.ren;
        i_ls_wen      = v.wen;
        i_ls_adr      = v.adr;
        i_ls_wdat     = v.wdat;
        i_mem_cmd_rdy = 1'b0;
        i_mem_rsp_val = 1'b0;
        i_mem_rsp_dat = v.dat;
        i_mem_rsp_err = v.rerr;
        while (!done && n < 100) begin
            tick();
            n++;
            if (i_mem_cmd_rdy) accepted = 1'b1;
            i_mem_cmd_rdy = 1'b0;
            i_mem_rsp_val = 1'b0;
            if (o_mem_cmd_val) begin
                cmd_cyc++;
                if (first_cmd < 0) first_cmd = n;
                chk({name, " adr"},   o_mem_adr, v.exp_adr);
                chk({name, " wdat"},  o_mem_wdat, v.wdat);
                chk({name, " wstrb"}, 32'(o_mem_wstrb), 32'(v.wen));
                chk({name, " wr"},    32'(o_mem_wr), 32'(v.exp_wr));
            end
            if (hs_ls4ex_rdy) begin
                done = 1'b1;
                chk({name, " latency"}, 32'(n), 32'(v.exp_lat));
                chk({name, " rdat"}, o_ls_rdat, v.exp_rdat);
                chk({name, " err"}, 32'(o_ls_err), 32'(v.exp_err));
            end else begin
                if (o_mem_cmd_val && !accepted) begin
                    if (wait_c == v.cw) i_mem_cmd_rdy = 1'b1;
                    else wait_c++;
                end
                if (accepted && !rsp_sent && o_mem_rsp_rdy) begin
                    if (rsp_c == v.rw) begin
                        i_mem_rsp_val = 1'b1;
                        rsp_sent = 1'b1;
                    end else begin
                        rsp_c++;
                    end
                end
            end
        end
        if (!done) chk({name, " rdy_seen"}, 32'd0, 32'd1);
        chk({name, " cmd_cycles"}, 32'(cmd_cyc), 32'(v.exp_ncmd));
        chk({name, " first_cmd"}, 32'(first_cmd), (v.exp_ncmd == 0) ? 32'hFFFF_FFFF : 32'd1);
        // Execute still holds the request for one more edge; nothing may relaunch
        tick();
        chk({name, " rdy_pulse"}, 32'(hs_ls4ex_rdy), 32'd0);
        chk({name, " no_relaunch"}, 32'(o_mem_cmd_val), 32'd0);
    endtask

    // Idle cycles with no request: bus must stay quiet
    task automatic idle(input int cycles, input string name);
        hs_ex4ls_val = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            i_mem_rsp_val = 1'b0;
            chk({name, " idle_rdy"}, 32'(hs_ls4ex_rdy), 32'd0);
            chk({name, " idle_cmd"}, 32'(o_mem_cmd_val), 32'd0);
            chk({name, " idle_rsp_rdy"}, 32'(o_mem_rsp_rdy), 32'd1);
        end
    endtask

    function automatic vec_t mk(input logic ren, input logic [3:0] wen, input logic [31:0] adr,
                                input logic [31:0] wdat, input int cw, input int rw,
                                input logic [31:0] dat, input logic rerr, input logic [31:0] ea,
                                input logic ew, input logic [31:0] ed, input logic ee,
                                input int el, input int en);
        vec_t v;
        v.ren = ren; v.wen = wen; v.adr = adr; v.wdat = wdat; v.cw = cw; v.rw = rw;
        v.dat = dat; v.rerr = rerr; v.exp_adr = ea; v.exp_wr = ew; v.exp_rdat = ed;
        v.exp_err = ee; v.exp_lat = el; v.exp_ncmd = en;
        return v;
    endfunction

    initial begin
        vec_t v;
        // Hand-computed directed vectors (TMO = 4)
        vecs[0] = mk(1'b1, 4'h0, 32'h0000_1006, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0,
                     32'h0000_1004, 1'b0, 32'hDEAD_BEEF, 1'b0, 3, 1);
        vecs[1] = mk(1'b0, 4'hC, 32'h0000_2000, 32'h1234_0000, 4, 0, 32'hCAFE_0000, 1'b0,
                     32'h0000_2000, 1'b1, 32'h0, 1'b0, 7, 5);
        vecs[2] = mk(1'b1, 4'h0, 32'h0000_300A, 32'h0, 1, 2, 32'h0000_0055, 1'b1,
                     32'h0000_3008, 1'b0, 32'h0000_0055, 1'b1, 6, 2);
        vecs[3] = mk(1'b0, 4'h0, 32'h0000_5000, 32'h0, 0, 0, 32'h7777_7777, 1'b0,
                     32'h0, 1'b0, 32'h0, 1'b0, 1, 0);
        vecs[4] = mk(1'b1, 4'hF, 32'h0000_4003, 32'hA5A5_A5A5, 0, 1, 32'hFFFF_FFFF, 1'b0,
                     32'h0000_4000, 1'b1, 32'h0, 1'b0, 4, 1);
        vecs[5] = mk(1'b1, 4'h0, 32'h0000_6004, 32'h0, 0, 99, 32'h1111_1111, 1'b0,
                     32'h0000_6004, 1'b0, 32'h0, 1'b1, 6, 1);
        vecs[6] = mk(1'b1, 4'h0, 32'h0000_7000, 32'h0, 2, 3, 32'h0BAD_0BAD, 1'b0,
                     32'h0000_7000, 1'b0, 32'h0BAD_0BAD, 1'b0, 8, 3);
        vecs[7] = mk(1'b1, 4'h0, 32'h0000_8000, 32'h0, 0, 4, 32'h1234_5678, 1'b0,
                     32'h0000_8000, 1'b0, 32'h0, 1'b1, 6, 1);

        rst_n = 1'b0; hs_ex4ls_val = 1'b0; i_ls_adr = 32'h0; i_ls_wdat = 32'h0;
        i_ls_wen = 4'h0; i_ls_ren = 1'b0; i_mem_cmd_rdy = 1'b0; i_mem_rsp_val = 1'b0;
        i_mem_rsp_dat = 32'h0; i_mem_rsp_err = 1'b0;

        // Reset state
        #2;
        chk("reset outputs", {o_mem_cmd_val, o_mem_rsp_rdy, hs_ls4ex_rdy, o_ls_err, o_mem_wr,
                              27'd0}, 32'd0);
        chk("reset rdat", o_ls_rdat, 32'h0);
        chk("reset adr", o_mem_adr | o_mem_wdat | {28'd0, o_mem_wstrb}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        idle(2, "post_reset");

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            idle(1, $sformatf("vec%0d", i));
        end

        // Timeout followed by a late response two cycles after rdy
        v = model(mk(1'b1, 4'h0, 32'h0000_9000, 32'h0, 1, 50, 32'h5555_AAAA, 1'b0,
                     32'h0, 1'b0, 32'h0, 1'b0, 0, 0));
        run_txn(v, "tmo_late");
        hs_ex4ls_val = 1'b0;
        i_mem_rsp_val = 1'b1;
        i_mem_rsp_dat = 32'h5555_AAAA;
        idle(5, "tmo_late");

        // Back-to-back requests with val held high
        v = model(mk(1'b1, 4'h0, 32'h0000_A000, 32'h0, 0, 0, 32'h0101_0101, 1'b0,
                     32'h0, 1'b0, 32'h0, 1'b0, 0, 0));
        run_txn(v, "b2b_a");
        v = model(mk(1'b0, 4'h3, 32'h0000_A104, 32'h0000_BEEF, 1, 1, 32'h0, 1'b0,
                     32'h0, 1'b0, 32'h0, 1'b0, 0, 0));
        run_txn(v, "b2b_b");
        idle(1, "b2b");

        // Reset while waiting for a response
        hs_ex4ls_val = 1'b1; i_ls_ren = 1'b1; i_ls_wen = 4'h2;
        i_ls_adr = 32'h0000_B00C; i_ls_wdat = 32'hFACE_0000;
        tick();
        chk("rst_mid cmd", 32'(o_mem_cmd_val), 32'd1);
        i_mem_cmd_rdy = 1'b1;
        tick();
        i_mem_cmd_rdy = 1'b0;
        chk("rst_mid in_rsp", 32'(o_mem_rsp_rdy), 32'd1);
        hs_ex4ls_val = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid ctl", {o_mem_cmd_val, o_mem_rsp_rdy, hs_ls4ex_rdy, o_ls_err, o_mem_wr,
                            27'd0}, 32'd0);
        chk("rst_mid fields", o_mem_adr | o_mem_wdat | o_ls_rdat | {28'd0, o_mem_wstrb}, 32'h0);
        tick();
        rst_n = 1'b1;
        i_mem_rsp_val = 1'b1;
        i_mem_rsp_dat = 32'h0BAD_F00D;
        idle(4, "rst_mid stale");

        // Random traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            v.ren  = 1'($urandom_range(0, 1));
            v.wen  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            v.adr  = $urandom;
            v.wdat = $urandom;
            v.cw   = $urandom_range(0, 3);
            v.rw   = $urandom_range(0, 5);
            v.dat  = $urandom;
            v.rerr = ($urandom_range(0, 4) == 0);
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), $sformatf("rnd%0d", i));
        end
        idle(1, "end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_bif.md
Name: lsu_bif

Overview:
- Load/store bus interface. Sits directly downstream of the execute stage's address-generation path.
- Accepts one load/store request at a time over the ex→ls valid/ready handshake and issues it on a split command/response memory bus.
- Returns read data and completion to execute; guards against hung slaves with a response timeout.

Parameters:
- TMO_CYC, 255, response-wait cycles before timeout; legal range 1..2^TMO_W-1
- TMO_W, 8, width of the timeout counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- hs_ex4ls_val  in  1  request valid from execute; held stable until hs_ls4ex_rdy
- hs_ls4ex_rdy  out  1  completion pulse to execute
- i_ls_adr  in  32  byte address
- i_ls_wdat  in  32  write data, already lane-positioned
- i_ls_wen  in  4  byte-lane write enables
- i_ls_ren  in  1  read request
- o_ls_rdat  out  32  raw read word, registered
- o_ls_err  out  1  bus error or timeout, qualified by hs_ls4ex_rdy
- o_mem_cmd_val  out  1  command valid
- i_mem_cmd_rdy  in  1  command accepted
- o_mem_adr  out  32  word address {adr[31:2],2'b00}
- o_mem_wdat  out  32  write data
- o_mem_wstrb  out  4  write strobes
- o_mem_wr  out  1  1 = write, 0 = read
- i_mem_rsp_val  in  1  response valid
- o_mem_rsp_rdy  out  1  response ready
- i_mem_rsp_dat  in  32  read data
- i_mem_rsp_err  in  1  slave error

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registered outputs 0: o_mem_*, o_ls_rdat, o_ls_err, hs_ls4ex_rdy, timeout counter.
- FSM states: IDLE, CMD, RSP, DONE.
- IDLE:
  - On hs_ex4ls_val with (i_ls_ren | any i_ls_wen): latch adr/wdat/wstrb; set o_mem_wr=|i_ls_wen (write wins over simultaneous ren); go to CMD.
  - On hs_ex4ls_val with ren=0, wen=0 (no-op): go to DONE with rdat=0, err=0.
  - o_mem_rsp_rdy=1; stray responses are silently discarded (covers responses still in flight from before a reset).
- CMD:
  - o_mem_cmd_val=1 with all command fields stable.
  - On i_mem_cmd_rdy go to RSP; clear the timeout counter.
  - No timeout while waiting for command acceptance.
- RSP:
  - o_mem_rsp_rdy=1.
  - On i_mem_rsp_val:
    - read: o_ls_rdat←i_mem_rsp_dat
    - write: o_ls_rdat←0
    - o_ls_err←i_mem_rsp_err
    - go to DONE.
  - Otherwise counter+1. When counter==TMO_CYC-1 with no response: rdat←0, err←1, go to DONE.
- DONE:
  - hs_ls4ex_rdy=1 for exactly one cycle; o_ls_rdat/o_ls_err valid that cycle.
  - Always go to IDLE; execute drops or replaces val after this cycle.
  - IDLE never re-launches in the same cycle as DONE.
- Latency: the minimum with zero-wait memory is 3 cycles from val first seen to rdy (IDLE→CMD→RSP→DONE).
- o_mem_rsp_rdy=0 in CMD and DONE; a response arriving in CMD is held off by the slave.
- Only one transaction outstanding; the bus never sees a second command before the response or timeout.
- Address bits [1:0] are dropped; misalignment is the execute stage's problem.
- Timeout path: a late response arriving afterwards in IDLE is discarded.
- Reset mid-transaction: immediate return to IDLE; cmd_val deasserts asynchronously.

Decomposition:
- cirno9_define.v gains:
  - CIRNO_LSB_ST_* state encodings (2-bit: IDLE=0, CMD=1, RSP=2, DONE=3)
  - CIRNO_LSB_TMO_DEF default
- Sub-module lsu_tmo: a clearable, enabled saturating counter with terminal-count output, parameterized by TMO_W/TMO_CYC.

Test Plan:
- Zero-wait read: adr=0x0000_1006, ren=1; cmd_rdy=1, rsp next cycle dat=0xDEAD_BEEF → o_mem_adr=0x0000_1004, wr=0; rdy at cycle 3 with rdat=0xDEADBEEF, err=0.
- Write with backpressure: wen=4'b1100, wdat=0x1234_0000; cmd_rdy low 4 cycles → cmd_val held 5 cycles with fields stable, wstrb=1100, wr=1; rdy one cycle after rsp, rdat=0.
- Timeout: TMO_CYC=4, read accepted, no rsp → rdy 4 cycles after entering RSP with err=1, rdat=0. A rsp_val injected 2 cycles later is consumed in IDLE with no rdy.
- Slave error plus no-op: a rsp with err=1 gives rdy with o_ls_err=1. A subsequent val with ren=0, wen=0 gives rdy one cycle later, no cmd_val ever.
- Priority and back-to-back:
  - ren=1 with wen=4'hF → wr=1.
  - Two requests back-to-back (val kept high with new adr after rdy) → second cmd appears 2 cycles after first rdy, no duplicate command.
- Reset mid-RSP: rst_n low for 1 cycle while waiting → all outputs 0 immediately, state IDLE; a stale rsp afterwards produces no rdy.
